// File: rtl/mem_arbiter_if.sv
// Client and memory bus bundle for mem_arbiter.
// The master side drives requests and memory read data; the slave side is the arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_flush;
    logic [15:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single fixed-latency memory.
// One transaction is outstanding at a time; a starvation counter bounds fetch losses.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          gnt_dm
);

    localparam logic [3:0] MemLat    = 4'(MEM_LAT);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  starve_q;
    logic [3:0]  cnt_q;
    logic        owner_dm_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] data_q;
    logic        discard_q;
    logic [15:0] if_rdata_q;
    logic [15:0] dm_rdata_q;

    logic        grant_if;
    logic        grant_dm;
    logic        if_deliver;
    logic [15:0] resp_data;

    // A flushing fetch never wins; a starved fetch beats a pending data request.
    assign grant_if   = bus.if_req && !bus.if_flush && (!bus.dm_req || starve_q == StarveMax);
    assign grant_dm   = bus.dm_req && !grant_if;
    assign resp_data  = we_q ? 16'h0000 : data_q;
    assign if_deliver = (state_q == StResp) && !owner_dm_q && !discard_q && !bus.if_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_if || grant_dm) state_d = StIssue;
            StIssue: state_d = we_q ? StResp : StWait;
            StWait:  if (cnt_q <= 4'd1) state_d = StResp;
            StResp:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            cnt_q      <= '0;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            discard_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_if || grant_dm) begin
                        owner_dm_q <= grant_dm;
                        we_q       <= grant_dm && bus.dm_we;
                        addr_q     <= grant_dm ? bus.dm_addr : bus.if_addr;
                        wdata_q    <= grant_dm ? bus.dm_wdata : 16'h0000;
                        discard_q  <= 1'b0;
                    end
                    if (grant_if) begin
                        starve_q <= '0;
                    end else if (grant_dm && bus.if_req && starve_q != StarveMax) begin
                        starve_q <= starve_q + 4'd1;
                    end
                end
                StIssue: begin
                    if (!we_q) cnt_q <= MemLat;
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) data_q <= bus.mem_rdata;
                end
                StResp: begin
                    if (owner_dm_q) dm_rdata_q <= resp_data;
                    else if (if_deliver) if_rdata_q <= resp_data;
                end
            endcase
            // A discarded fetch still runs to completion so the memory sees a clean access.
            if (state_q != StIdle && !owner_dm_q && bus.if_flush) discard_q <= 1'b1;
        end
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == StIssue) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
        end
        busy         = (state_q != StIdle);
        gnt_dm       = busy && owner_dm_q;
        bus.if_ready = if_deliver;
        bus.dm_ready = (state_q == StResp) && owner_dm_q;
        bus.if_rdata = if_deliver ? resp_data : if_rdata_q;
        bus.dm_rdata = bus.dm_ready ? resp_data : dm_rdata_q;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from the memory issue cycle until mem_rdata is valid; legal range 1-15.
REQ-002 Parameter STARVE_MAX, default 3: consecutive arbitrations the instruction port may lose before it is forced to win; legal range 1-15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; held until if_ready or if_flush.
REQ-006 if_addr  input  16  fetch word address; stable while if_req=1.
REQ-007 if_flush  input  1  discards the pending or in-flight fetch (branch redirect).
REQ-008 if_rdata  output  16  fetched word; valid when if_ready=1.
REQ-009 if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 dm_req  input  1  data-port request; held until dm_ready.
REQ-011 dm_we  input  1  1 = write, 0 = read.
REQ-012 dm_addr  input  16  data word address.
REQ-013 dm_wdata  input  16  store data.
REQ-014 dm_rdata  output  16  load data; valid when dm_ready=1.
REQ-015 dm_ready  output  1  one-cycle data completion pulse.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  16  memory address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory read data.
REQ-021 busy  output  1  1 in every state except IDLE.
REQ-022 gnt_dm  output  1  1 while the data port owns the transaction.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; at most one transaction is outstanding.
REQ-024 Arbitration in IDLE: dm_req=1 wins, unless if_req=1 and starve_cnt=STARVE_MAX, in which case IF wins.
REQ-025 IF SHALL win when only if_req=1 and if_flush=0.
REQ-026 The arbiter SHALL latch the winner's address, we and wdata, then move IDLE->ISSUE.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_MAX, when both ports request and DM wins; it SHALL clear when IF wins.
REQ-028 ISSUE lasts exactly one cycle: mem_en=1 and mem_addr, mem_we and mem_wdata driven from the latches; mem_en=0 in all other states.
REQ-029 ISSUE transitions: a write goes to RESP; a read goes to WAIT with the counter loaded to MEM_LAT.
REQ-030 WAIT SHALL last MEM_LAT cycles; mem_rdata is captured into the data latch at the end of the last WAIT cycle, then the FSM goes to RESP.
REQ-031 RESP lasts one cycle: the owner's ready=1 and rdata = data latch (writes return 0x0000); the FSM then goes to IDLE.
REQ-032 Latency from request sampled in IDLE (cycle 0): read ready in cycle MEM_LAT+2; write ready in cycle 2.
REQ-033 if_rdata and dm_rdata SHALL hold their last value between ready pulses.
REQ-034 if_flush=1 in IDLE SHALL block an IF grant that cycle.
REQ-035 if_flush=1 during ISSUE/WAIT/RESP of an IF transaction SHALL mark it discarded: the memory access completes, if_ready stays 0 and if_rdata is not updated.
REQ-036 A flush coinciding with RESP SHALL also suppress if_ready.
REQ-037 A request withdrawn mid-transaction SHALL not abort it; the ready pulse still occurs.
REQ-038 if_ready and dm_ready SHALL never both be 1.

Reset
REQ-039 rst=1 SHALL, at the next edge, force IDLE, clear starve_cnt, the counter, the latches and the discard flag, and drive all outputs to 0.
REQ-040 Reset mid-transaction abandons it with no ready pulse.
REQ-041 rst SHALL take priority over all other inputs.

Verification
REQ-042 MEM_LAT=2: if_req, if_addr=0x0010, mem_rdata=0x1234 in cycle 3 -> mem_en=1 only in cycle 1 with mem_addr=0x0010; if_ready=1, if_rdata=0x1234 in cycle 4.
REQ-043 if_req and dm_req read (dm_addr=0x0040) both rise in cycle 0 -> gnt_dm=1, mem_addr=0x0040 in cycle 1, dm_ready in cycle 4; fetch issues in cycle 6, if_ready in cycle 9.
REQ-044 dm_req write, dm_addr=0x0040, dm_wdata=0xBEEF -> cycle 1 mem_en=mem_we=1 with mem_wdata=0xBEEF; dm_ready=1, dm_rdata=0x0000 in cycle 2.
REQ-045 STARVE_MAX=3, dm_req and if_req held continuously -> DM wins arbitrations 1-3, IF wins arbitration 4, then starve_cnt=0.
REQ-046 if_flush pulsed during WAIT of a fetch -> no if_ready, busy=0 after RESP, a new if_addr=0x0020 completes normally.
REQ-047 rst=1 in WAIT of a DM read -> next cycle busy, mem_en, dm_ready and gnt_dm are all 0; no ready pulse follows.
